// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity mode encodings and
// the clocks-per-bit helper used by both the TX and RX sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..DIV-1 while enabled, flags the last cycle of
// each bit period, and is forced to zero when cleared or disabled.
module uart_bit_timer #(
  parameter int DIV = 2,
  parameter int CW  = 1
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          en_i,
  input  logic          clear_i,
  output logic          bit_end_o,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q, count_d;

  assign bit_end_o = (count_q == CW'(DIV - 1));
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear_i || !en_i || bit_end_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, one or two stop
// bits, with zero-gap back-to-back frames. Parity support is compiled in only
// when UART_TX_FRAME_PARITY_EN is defined; otherwise par_mode is ignored.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        par_mode,
  input  logic              two_stop,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_frame: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_width_check
    $error("uart_tx_frame: DATA_W must be in 5..9");
  end

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic              two_stop_q, two_stop_d;
  logic              tx_out_q, tx_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end, accept, last_stop;
  logic [CW-1:0]     count;

`ifdef UART_TX_FRAME_PARITY_EN
  logic [DATA_W-1:0] word_q, word_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              par_bit;

  assign par_bit = (^word_q) ^ par_odd_q;
`else
  logic unused_par_mode;

  assign unused_par_mode = ^par_mode;
`endif

  uart_bit_timer #(
    .DIV (DIV),
    .CW  (CW)
  ) u_timer (
    .clock_i   (clock),
    .reset_ni  (reset),
    .en_i      (state_q != IDLE),
    .clear_i   (accept),
    .bit_end_o (bit_end),
    .count_o   (count)
  );

  // With two stop bits the index tells the first stop bit from the second.
  assign last_stop = !two_stop_q || bit_idx_q[0];
  assign tx_ready  = (state_q == IDLE) || ((state_q == STOP) && bit_end && last_stop);
  assign accept    = tx_valid && tx_ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    two_stop_d = two_stop_q;
`ifdef UART_TX_FRAME_PARITY_EN
    word_d     = word_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'(DATA_W - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_FRAME_PARITY_EN
            state_d   = par_en_q ? PARITY : STOP;
`else
            state_d   = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_FRAME_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!last_stop) begin
            bit_idx_d = bit_idx_q + 4'd1;
          end else begin
            bit_idx_d = '0;
            state_d   = accept ? START : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The frame's word and mode are captured once, so later input changes are inert.
    if (accept) begin
      shift_d    = tx_data;
      two_stop_d = two_stop;
      bit_idx_d  = '0;
`ifdef UART_TX_FRAME_PARITY_EN
      word_d     = tx_data;
      par_en_d   = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
      par_odd_d  = (par_mode == PAR_ODD);
`endif
    end
  end

  // Outputs are registered from the next state so the line tracks the FSM
  // without a cycle of lag; done looks one cycle ahead to land on the final
  // stop cycle together with tx_ready.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_FRAME_PARITY_EN
      PARITY:  tx_out_d = par_bit;
`endif
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && last_stop && (count == CW'(DIV - 2));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      two_stop_q <= 1'b0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_FRAME_PARITY_EN
      word_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      two_stop_q <= two_stop_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_FRAME_PARITY_EN
      word_q     <= word_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
`endif
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at DIV=8 with DATA_W 8, 5 and 9 instances;
// expectations follow UART_TX_FRAME_PARITY_EN when it is defined.
module tb_uart_tx_frame;

`ifdef UART_TX_FRAME_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       txValid = 1'b0;
  logic [8:0] txData = '0;
  logic [1:0] parMode = 2'b00;
  logic       twoStop = 1'b0;
  logic [1:0] sel = 2'd0;

  logic txReady8, txOut8, busy8, done8;
  logic txReady5, txOut5, busy5, done5;
  logic txReady9, txOut9, busy9, done9;
  logic obsReady, obsTxOut, obsBusy, obsDone;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  uart_tx_frame #(.DATA_W(8), .CLK_HZ(1_000_000), .BAUD(125_000)) dut8 (
    .clock(clock), .reset(reset), .tx_valid(txValid && sel == 2'd0), .tx_ready(txReady8),
    .tx_data(txData[7:0]), .par_mode(parMode), .two_stop(twoStop),
    .tx_out(txOut8), .busy(busy8), .done(done8)
  );

  uart_tx_frame #(.DATA_W(5), .CLK_HZ(1_000_000), .BAUD(125_000)) dut5 (
    .clock(clock), .reset(reset), .tx_valid(txValid && sel == 2'd1), .tx_ready(txReady5),
    .tx_data(txData[4:0]), .par_mode(parMode), .two_stop(twoStop),
    .tx_out(txOut5), .busy(busy5), .done(done5)
  );

  uart_tx_frame #(.DATA_W(9), .CLK_HZ(1_000_000), .BAUD(125_000)) dut9 (
    .clock(clock), .reset(reset), .tx_valid(txValid && sel == 2'd2), .tx_ready(txReady9),
    .tx_data(txData), .par_mode(parMode), .two_stop(twoStop),
    .tx_out(txOut9), .busy(busy9), .done(done9)
  );

  assign obsReady = (sel == 2'd0) ? txReady8 : (sel == 2'd1) ? txReady5 : txReady9;
  assign obsTxOut = (sel == 2'd0) ? txOut8   : (sel == 2'd1) ? txOut5   : txOut9;
  assign obsBusy  = (sel == 2'd0) ? busy8    : (sel == 2'd1) ? busy5    : busy9;
  assign obsDone  = (sel == 2'd0) ? done8    : (sel == 2'd1) ? done5    : done9;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line levels for one frame, bit 0 = start bit; everything past parity is mark.
  function automatic logic [23:0] mkFrame(input logic [8:0] d, input int w,
                                          input bit hasPar, input logic parBit);
    logic [23:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    for (int i = 0; i < w; i++) begin
      f[n] = d[i];
      n++;
    end
    if (hasPar) f[n] = parBit;
    return f;
  endfunction

  // Called at a falling edge; returns at the falling edge of frame cycle 1.
  task automatic applyStimulus(input logic [1:0] which, input logic [8:0] d,
                               input logic [1:0] pm, input logic ts);
    int waitCnt;
    waitCnt = 0;
    sel = which;
    txData = d;
    parMode = pm;
    twoStop = ts;
    txValid = 1'b1;
    while (!obsReady && waitCnt < 300) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!obsReady) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  task automatic checkLine(input string name, input logic [23:0] expBits, input int nBits,
                           input int frameCyc, input int dropCyc, input logic [8:0] nextData,
                           input bit scramble);
    logic [7:0] samp;
    int doneErr, busyErr, readyErr, c;
    doneErr = 0;
    busyErr = 0;
    readyErr = 0;
    for (int b = 0; b < nBits; b++) begin
      for (int k = 0; k < 8; k++) begin
        c = b * 8 + k + 1;
        samp[k] = obsTxOut;
        if (obsBusy !== 1'b1) busyErr++;
        if (obsDone !== (c % frameCyc == 0)) doneErr++;
        if (obsReady !== (c % frameCyc == 0)) readyErr++;
        if (c == 1) txData = nextData;
        if (c == dropCyc) txValid = 1'b0;
        if (scramble) begin
          txData = 9'($urandom);
          parMode = 2'($urandom);
          twoStop = 1'($urandom);
        end
        @(negedge clock);
      end
      checkOutput($sformatf("%s_bit%0d", name, b), 32'(samp), 32'({8{expBits[b]}}));
    end
    checkOutput({name, "_doneTiming"}, 32'(doneErr), 32'd0);
    checkOutput({name, "_busyHeld"}, 32'(busyErr), 32'd0);
    checkOutput({name, "_readyTiming"}, 32'(readyErr), 32'd0);
  endtask

  task automatic runFrame(input string name, input logic [1:0] which, input logic [8:0] d,
                          input logic [1:0] pm, input logic ts, input logic [23:0] expBits,
                          input int nBits, input bit scramble);
    applyStimulus(which, d, pm, ts);
    checkLine(name, expBits, nBits, nBits * 8, 1, d, scramble);
    checkOutput({name, "_idleLine"}, 32'(obsTxOut), 32'd1);
    checkOutput({name, "_idleBusy"}, 32'(obsBusy), 32'd0);
    checkOutput({name, "_idleDone"}, 32'(obsDone), 32'd0);
  endtask

  initial begin
    logic [23:0] b2b;
    $display("[TB] uart_tx_frame bench, parity support = %0d", PAR_ON);
    repeat (3) @(negedge clock);
    checkOutput("reset_txOut", 32'(txOut8), 32'd1);
    checkOutput("reset_ready", 32'(txReady8), 32'd1);
    checkOutput("reset_busy", 32'(busy8), 32'd0);
    checkOutput("reset_done", 32'(done8), 32'd0);
    reset = 1'b1;

    // No valid: the line must sit at mark with nothing happening.
    repeat (20) @(negedge clock);
    checkOutput("quiet_txOut", 32'(txOut8), 32'd1);
    checkOutput("quiet_busy", 32'(busy8), 32'd0);

    // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
    runFrame("a5_8N1", 2'd0, 9'h0A5, 2'b00, 1'b0, 24'hFFF34A, 10, 1'b0);

    // 0x07 even, two stops: three ones -> parity 1
    runFrame("07_8E2", 2'd0, 9'h007, 2'b01, 1'b1, mkFrame(9'h007, 8, PAR_ON, 1'b1),
             11 + int'(PAR_ON), 1'b0);
    // 0x07 odd, one stop: parity 0
    runFrame("07_8O1", 2'd0, 9'h007, 2'b10, 1'b0, mkFrame(9'h007, 8, PAR_ON, 1'b0),
             10 + int'(PAR_ON), 1'b0);
    // Mode 11 means no parity even when parity support is built in.
    runFrame("07_mode11", 2'd0, 9'h007, 2'b11, 1'b0, mkFrame(9'h007, 8, 1'b0, 1'b0),
             10, 1'b0);

    // Back-to-back 0x55 then 0xAA with valid held high.
    b2b = (mkFrame(9'h0AA, 8, 1'b0, 1'b0) << 10) | (mkFrame(9'h055, 8, 1'b0, 1'b0) & 24'h0003FF);
    applyStimulus(2'd0, 9'h055, 2'b00, 1'b0);
    checkLine("b2b", b2b, 20, 80, 81, 9'h0AA, 1'b0);
    checkOutput("b2b_idleLine", 32'(txOut8), 32'd1);
    checkOutput("b2b_idleBusy", 32'(busy8), 32'd0);

    // Reset pulled low at cycle 37 of a frame.
    applyStimulus(2'd0, 9'h03C, 2'b00, 1'b0);
    txValid = 1'b0;
    for (int i = 1; i < 37; i++) @(negedge clock);
    checkOutput("midFrame_busy", 32'(busy8), 32'd1);
    checkOutput("midFrame_txOut", 32'(txOut8), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_txOut", 32'(txOut8), 32'd1);
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_ready", 32'(txReady8), 32'd1);
    checkOutput("abort_done", 32'(done8), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    runFrame("3c_afterReset", 2'd0, 9'h03C, 2'b00, 1'b0, mkFrame(9'h03C, 8, 1'b0, 1'b0),
             10, 1'b0);

    // Inputs scrambled every cycle after accept; 0xC3 has four ones -> even parity 0.
    runFrame("c3_scrambled", 2'd0, 9'h0C3, 2'b01, 1'b0, mkFrame(9'h0C3, 8, PAR_ON, 1'b0),
             10 + int'(PAR_ON), 1'b1);

    // DATA_W=5: 0x1F with two stops is an 8-bit, 64-cycle frame.
    runFrame("w5_1F", 2'd1, 9'h01F, 2'b00, 1'b1, mkFrame(9'h01F, 5, 1'b0, 1'b0), 8, 1'b0);
    // DATA_W=9: 0x1FF has nine ones -> even parity 1.
    runFrame("w9_1FF", 2'd2, 9'h1FF, 2'b01, 1'b0, mkFrame(9'h1FF, 9, PAR_ON, 1'b1),
             11 + int'(PAR_ON), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
